hiscore_ioctl_master: RTL and testbench

//  ioctl bus initiator that drives the hiscore block's ioctl slave port from inside the FPGA.

---
 rtl/hiscore_pkg.sv | 42 ++++
 rtl/hs_cfg_rom.sv | 25 ++
 rtl/hiscore_ioctl_master.sv | 180 ++++++++++++++++++
 tb/tb_hiscore_ioctl_master.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hiscore_pkg.sv
// Shared definitions for the hiscore ioctl master: FSM state codes, transfer index defaults,
// default config table and the checksum step (CRC-16/CCITT-FALSE when HS_IOCTL_MASTER_CRC_EN is defined).
package hiscore_pkg;

    localparam int HS_CONFIGINDEX_DEF = 3;
    localparam int HS_DUMPINDEX_DEF   = 4;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_DL_SETUP = 4'd1;
    localparam logic [3:0] ST_DL_WR    = 4'd2;
    localparam logic [3:0] ST_DL_GAP   = 4'd3;
    localparam logic [3:0] ST_DL_END   = 4'd4;
    localparam logic [3:0] ST_UL_SETUP = 4'd5;
    localparam logic [3:0] ST_UL_WAIT  = 4'd6;
    localparam logic [3:0] ST_UL_CAP   = 4'd7;
    localparam logic [3:0] ST_UL_END   = 4'd8;

    // Byte 0 sits in bits [7:0]: 00 00 43 0B 0F 10 01 00, repeated twice.
    localparam logic [127:0] HS_CFG_DEFAULT = 128'h0001100F0B430000_0001100F0B430000;

`ifdef HS_IOCTL_MASTER_CRC_EN
    localparam logic [15:0] HS_CRC_POLY = 16'h1021;
    localparam logic [15:0] HS_CRC_INIT = 16'hFFFF;
    localparam logic [15:0] HS_ACC_INIT = HS_CRC_INIT;
`else
    localparam logic [15:0] HS_ACC_INIT = 16'h0000;
`endif

    function automatic logic [15:0] hs_csum_step(input logic [15:0] acc, input logic [7:0] data);
        logic [15:0] crc;
`ifdef HS_IOCTL_MASTER_CRC_EN
        crc = acc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            crc = crc[15] ? ((crc << 1) ^ HS_CRC_POLY) : (crc << 1);
        end
`else
        crc = acc + {8'h00, data};
`endif
        return crc;
    endfunction

endpackage

// File: rtl/hs_cfg_rom.sv
// Single-port synchronous config ROM, one-cycle read latency; contents compiled in through CFG_TABLE.
module hs_cfg_rom
    import hiscore_pkg::*;
#(
    parameter int                     CFG_BYTES = 16,
    parameter int                     AW        = $clog2(CFG_BYTES),
    parameter logic [8*CFG_BYTES-1:0] CFG_TABLE = HS_CFG_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    output logic [7:0]    q
);

    // NOTE: the table itself is constant and needs no reset; only the output register is
    // cleared so the byte presented to the slave is 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 8'h00;
        end else begin
            q <= CFG_TABLE[{addr, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/hiscore_ioctl_master.sv
// ioctl initiator for the hiscore block: replays the config table as a download and checksums
// an upload of the score dump. Build option HS_IOCTL_MASTER_CRC_EN selects CRC-16 instead of a byte sum.
module hiscore_ioctl_master
    import hiscore_pkg::*;
#(
    parameter int                     HS_CONFIGINDEX = HS_CONFIGINDEX_DEF,
    parameter int                     HS_DUMPINDEX   = HS_DUMPINDEX_DEF,
    parameter int                     CFG_BYTES      = 16,
    parameter int                     DUMP_BYTES     = 64,
    parameter int                     WR_GAP         = 4,
    parameter int                     RD_LAT         = 4,
    parameter logic [8*CFG_BYTES-1:0] CFG_TABLE      = HS_CFG_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_cfg,
    input  logic        start_upload,
    output logic        ioctl_download,
    output logic        ioctl_upload,
    output logic        ioctl_wr,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_din,
    output logic [7:0]  ioctl_index,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum,
    output logic        changed
);

    localparam int          AW        = $clog2(CFG_BYTES);
    localparam logic [24:0] CFG_LAST  = 25'(CFG_BYTES - 1);
    localparam logic [24:0] DUMP_LAST = 25'(DUMP_BYTES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(WR_GAP - 1);
    localparam logic [15:0] LAT_LOAD  = 16'(RD_LAT - 1);
    localparam logic [15:0] END_LOAD  = 16'd1;

    logic [3:0]  state;
    logic [15:0] cnt;
    logic [15:0] acc;
    logic [15:0] acc_next;
    logic        pend_cfg;
    logic        pend_up;
    logic        have_prev;

    // The ROM follows ioctl_addr directly; the address advances on the first gap cycle,
    // so the next byte is ready well before the following write strobe.
    hs_cfg_rom #(
        .CFG_BYTES (CFG_BYTES),
        .AW        (AW),
        .CFG_TABLE (CFG_TABLE)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (ioctl_addr[AW-1:0]),
        .q     (ioctl_dout)
    );

    assign acc_next = hs_csum_step(acc, ioctl_din);
    assign busy     = (state != ST_IDLE);

    // NOTE: every register here uses non-blocking assignment so all updates in one edge see
    // the same pre-edge values; blocking assignment would make order of statements matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            acc            <= '0;
            pend_cfg       <= 1'b0;
            pend_up        <= 1'b0;
            have_prev      <= 1'b0;
            ioctl_download <= 1'b0;
            ioctl_upload   <= 1'b0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_index    <= '0;
            done           <= 1'b0;
            checksum       <= '0;
            changed        <= 1'b0;
        end else begin
            done     <= 1'b0;
            ioctl_wr <= 1'b0;
            pend_cfg <= pend_cfg | start_cfg;
            pend_up  <= pend_up | start_upload;

            case (state)
                ST_IDLE: begin
                    if (pend_cfg) begin
                        state          <= ST_DL_SETUP;
                        pend_cfg       <= start_cfg;
                        ioctl_download <= 1'b1;
                        ioctl_index    <= 8'(HS_CONFIGINDEX);
                        ioctl_addr     <= '0;
                    end else if (pend_up) begin
                        state        <= ST_UL_SETUP;
                        pend_up      <= start_upload;
                        ioctl_upload <= 1'b1;
                        ioctl_index  <= 8'(HS_DUMPINDEX);
                        ioctl_addr   <= '0;
                        acc          <= HS_ACC_INIT;
                        changed      <= 1'b0;
                    end
                end

                ST_DL_SETUP: begin
                    state    <= ST_DL_WR;
                    ioctl_wr <= 1'b1;
                end

                ST_DL_WR: begin
                    if (ioctl_addr == CFG_LAST) begin
                        state          <= ST_DL_END;
                        ioctl_download <= 1'b0;
                        cnt            <= END_LOAD;
                    end else begin
                        state      <= ST_DL_GAP;
                        ioctl_addr <= ioctl_addr + 25'd1;
                        cnt        <= GAP_LOAD;
                    end
                end

                ST_DL_GAP: begin
                    if (cnt == '0) begin
                        state    <= ST_DL_WR;
                        ioctl_wr <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                ST_UL_SETUP: begin
                    state <= ST_UL_WAIT;
                    cnt   <= LAT_LOAD;
                end

                ST_UL_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_UL_CAP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                ST_UL_CAP: begin
                    acc <= acc_next;
                    if (ioctl_addr == DUMP_LAST) begin
                        // checksum doubles as the stored value compared against by the next upload
                        state        <= ST_UL_END;
                        ioctl_upload <= 1'b0;
                        checksum     <= acc_next;
                        changed      <= !have_prev || (acc_next != checksum);
                        have_prev    <= 1'b1;
                        cnt          <= END_LOAD;
                    end else begin
                        state      <= ST_UL_WAIT;
                        ioctl_addr <= ioctl_addr + 25'd1;
                        cnt        <= LAT_LOAD;
                    end
                end

                // Two quiet cycles let the slave see the window fall with a stable index.
                ST_DL_END, ST_UL_END: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                default: begin
                    state          <= ST_IDLE;
                    ioctl_download <= 1'b0;
                    ioctl_upload   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hiscore_ioctl_master.sv
// Scoreboard bench for hiscore_ioctl_master: write strobes and done pulses are checked by
// monitors against queues filled when stimulus is issued.
module tb_hiscore_ioctl_master;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    typedef struct {
        bit          is_ul;
        logic [15:0] csum;
        logic        chg;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_cfg = 1'b0;
    logic        start_upload = 1'b0;
    logic        start_upload9 = 1'b0;
    logic        start_cfg9 = 1'b0;

    logic        download, upload, wr, busy, done, changed;
    logic [24:0] addr;
    logic [7:0]  dout, din, index;
    logic [15:0] checksum;

    logic        download9, upload9, wr9, busy9, done9, changed9;
    logic [24:0] addr9;
    logic [7:0]  dout9, din9, index9;
    logic [15:0] checksum9;

    logic [7:0]  dump_mem [4];
    logic [7:0]  msg9 [9];
    logic [7:0]  cfg_bytes [16];

    wr_exp_t     exp_wr[$];
    done_exp_t   exp_done[$];
    logic [15:0] exp_done9[$];

    int          checks = 0;
    int          errors = 0;
    int          done_count = 0;
    int          done9_count = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          overlap = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign din  = dump_mem[addr[1:0]];
    assign din9 = (addr9 < 25'd9) ? msg9[addr9[3:0]] : 8'h00;

    hiscore_ioctl_master #(.DUMP_BYTES(4)) dut (
        .clk(clk), .reset(reset), .start_cfg(start_cfg), .start_upload(start_upload),
        .ioctl_download(download), .ioctl_upload(upload), .ioctl_wr(wr), .ioctl_addr(addr),
        .ioctl_dout(dout), .ioctl_din(din), .ioctl_index(index), .busy(busy), .done(done),
        .checksum(checksum), .changed(changed)
    );

    hiscore_ioctl_master #(.DUMP_BYTES(9)) dut9 (
        .clk(clk), .reset(reset), .start_cfg(start_cfg9), .start_upload(start_upload9),
        .ioctl_download(download9), .ioctl_upload(upload9), .ioctl_wr(wr9), .ioctl_addr(addr9),
        .ioctl_dout(dout9), .ioctl_din(din9), .ioctl_index(index9), .busy(busy9), .done(done9),
        .checksum(checksum9), .changed(changed9)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] ref_csum(input logic [7:0] b0, b1, b2, b3);
        logic [7:0]  bytes [4];
        logic [15:0] r;
        bytes = '{b0, b1, b2, b3};
`ifdef HS_IOCTL_MASTER_CRC_EN
        r = 16'hFFFF;
        foreach (bytes[k]) begin
            for (int j = 7; j >= 0; j--) begin
                r = ((r[15] ^ bytes[k][j]) != 1'b0) ? ((r << 1) ^ 16'h1021) : (r << 1);
            end
        end
`else
        r = 16'h0000;
        foreach (bytes[k]) r = r + 16'(bytes[k]);
`endif
        return r;
    endfunction

    // Monitor: every strobe and done pulse is matched against the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (download && upload) overlap++;
            if (wr && upload) overlap++;
            if (download9 && upload9) overlap++;
            if (wr9) overlap++;
            if (wr) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_wr", 32'(addr), 32'hFFFF_FFFF);
                end else begin
                    wr_exp_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(addr), 32'(e.addr));
                    check("wr_dout", 32'(dout), 32'(e.data));
                    check("wr_window_index", {23'd0, download, index}, {23'd0, 1'b1, 8'd3});
                    if (e.addr != 25'd0) check("wr_spacing", 32'(cyc - last_wr_cyc), 32'd5);
                    last_wr_cyc = cyc;
                end
            end
            if (done) begin
                done_count++;
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_exp_t d;
                    d = exp_done.pop_front();
                    check("done_kind_index", 32'(index), d.is_ul ? 32'd4 : 32'd3);
                    check("done_windows_closed", {30'd0, download, upload}, 32'd0);
                    if (d.is_ul) begin
                        check("checksum", 32'(checksum), 32'(d.csum));
                        check("changed", 32'(changed), 32'(d.chg));
                    end
                end
            end
            if (done9) begin
                done9_count++;
                if (exp_done9.size() == 0) begin
                    check("unexpected_done9", 32'd1, 32'd0);
                end else begin
                    logic [15:0] c;
                    c = exp_done9.pop_front();
                    check("checksum9", 32'(checksum9), 32'(c));
                    check("changed9_index9", {23'd0, changed9, index9}, {23'd0, 1'b1, 8'd4});
                end
            end
        end
    end

    task automatic push_cfg();
        for (int i = 0; i < 16; i++) exp_wr.push_back('{addr: 25'(i), data: cfg_bytes[i]});
        exp_done.push_back('{is_ul: 1'b0, csum: 16'h0, chg: 1'b0});
    endtask

    task automatic push_ul(input logic [15:0] csum, input logic chg);
        exp_done.push_back('{is_ul: 1'b1, csum: csum, chg: chg});
    endtask

    task automatic pulse(input bit cfg, input bit up);
        @(negedge clk);
        start_cfg    = cfg;
        start_upload = up;
        @(negedge clk);
        start_cfg    = 1'b0;
        start_upload = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_count < target) check({name, "_timeout"}, 32'(done_count), 32'(target));
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] sum_a, sum_b;
        logic [63:0] half;
        half = 64'h0001100F0B430000;
        for (int i = 0; i < 16; i++) cfg_bytes[i] = half[(i % 8) * 8 +: 8];
        dump_mem = '{8'h01, 8'h02, 8'h03, 8'h04};
        msg9     = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        sum_a    = ref_csum(8'h01, 8'h02, 8'h03, 8'h04);   // 0x000A in sum mode
        sum_b    = ref_csum(8'h01, 8'h02, 8'h07, 8'h04);   // 0x000E in sum mode

        repeat (3) @(negedge clk);
        check("reset_windows", {29'd0, download, upload, wr}, 32'd0);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_dout_index", {16'd0, dout, index}, 32'd0);
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        check("reset_checksum_changed", {15'd0, checksum, changed}, 32'd0);
        reset = 1'b0;

        push_cfg();
        pulse(1'b1, 1'b0);
        wait_dones(1, 300, "download");
        check("busy_after_download", 32'(busy), 32'd0);

        push_ul(sum_a, 1'b1);
        pulse(1'b0, 1'b1);
        wait_dones(2, 200, "upload1");

        push_ul(sum_a, 1'b0);
        pulse(1'b0, 1'b1);
        wait_dones(3, 200, "upload2");

        dump_mem[2] = 8'h07;
        push_ul(sum_b, 1'b1);
        pulse(1'b0, 1'b1);
        wait_dones(4, 200, "upload3");

        push_cfg();
        push_ul(sum_b, 1'b0);
        pulse(1'b1, 1'b1);
        wait_dones(6, 500, "cfg_then_upload");

        // Abort an upload while byte 2 is on the bus.
        pulse(1'b0, 1'b1);
        begin
            int n = 0;
            while (!(upload && addr == 25'd2) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("reached_byte2", {31'd0, upload}, 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort_upload_busy", {30'd0, upload, busy}, 32'd0);
        check("abort_clears_result", {15'd0, checksum, changed}, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_count), 32'd6);

        push_ul(sum_b, 1'b1);
        pulse(1'b0, 1'b1);
        wait_dones(7, 200, "upload_after_abort");

`ifdef HS_IOCTL_MASTER_CRC_EN
        exp_done9.push_back(16'h29B1);
`else
        exp_done9.push_back(16'h01DD);
`endif
        @(negedge clk);
        start_upload9 = 1'b1;
        @(negedge clk);
        start_upload9 = 1'b0;
        begin
            int n = 0;
            while (done9_count < 1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("upload9_done", 32'(done9_count), 32'd1);
        end

        repeat (5) @(negedge clk);
        check("no_window_overlap", 32'(overlap), 32'd0);
        check("scoreboard_drained", 32'(exp_wr.size() + exp_done.size() + exp_done9.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
